// File: rtl/transmitter_if.sv
// Parallel-to-serial UART transmit interface: the transmitter is the slave side.
// The client drives baudTick and the load request and watches the serial line and status.
interface transmitter_if #(
  parameter int DBIT = 8
);
  logic            baudTick;
  logic            tx_start;
  logic [DBIT-1:0] tx_in;
  logic            tx;
  logic            tx_busy;
  logic            tx_done;

  modport master (
    output baudTick, tx_start, tx_in,
    input  tx, tx_busy, tx_done
  );

  modport slave (
    input  baudTick, tx_start, tx_in,
    output tx, tx_busy, tx_done
  );
endinterface

// File: rtl/transmitter.sv
// UART transmitter: start bit, DBIT data bits LSB first, then a stop bit of SB_TICK ticks.
// Every bit is timed by 16 baudTick pulses; tx is driven straight from a flop.
module transmitter #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input logic           clock,
  input logic           reset,
  transmitter_if.slave  bus
);

  localparam int BW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [3:0]    TICK_LAST = 4'd15;
  localparam logic [3:0]    STOP_LAST = 4'(SB_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DBIT - 1);

  logic [1:0]      state_q, state_d;
  logic [3:0]      tick_q, tick_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [DBIT-1:0] shift_q, shift_d;
  logic [DBIT-1:0] shift_nxt;
  logic            tx_q, tx_d;
  logic            done_q, done_d;

  assign shift_nxt = shift_q >> 1;

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (bus.tx_start) begin
          shift_d = bus.tx_in;
          tick_d  = 4'd0;
          bit_d   = '0;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (bus.baudTick) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = 4'd0;
            tx_d    = shift_q[0];
            state_d = DATA;
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (bus.baudTick) begin
          if (tick_q == TICK_LAST) begin
            tick_d = 4'd0;
            if (bit_q == BIT_LAST) begin
              tx_d    = 1'b1;
              state_d = STOP;
            end else begin
              // Next bit goes out on the same edge the register shifts.
              shift_d = shift_nxt;
              bit_d   = bit_q + BW'(1);
              tx_d    = shift_nxt[0];
            end
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end
      STOP: begin
        if (bus.baudTick) begin
          if (tick_q == STOP_LAST) begin
            tick_d  = 4'd0;
            tx_d    = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tick_q  <= 4'd0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign bus.tx      = tx_q;
  assign bus.tx_busy = (state_q != IDLE);
  assign bus.tx_done = done_q;

endmodule
